// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I(+M) decode stage with load-use bubble, flush and stall counter
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_inst,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    output logic             id_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_imm,
    output logic [4:0]       op1_addr,
    output logic [4:0]       op2_addr,
    output logic [4:0]       rd_addr,
    output logic [4:0]       fn,
    output logic [1:0]       op1,
    output logic [2:0]       op2,
    output logic             mem_wen,
    output logic             rf_wen,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] hazard_cnt
);
    localparam logic [4:0] ALU_X = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3, ALU_OR = 5'd4;
    localparam logic [4:0] ALU_XOR = 5'd5, ALU_SLL = 5'd6, ALU_SRL = 5'd7, ALU_SRA = 5'd8, ALU_SLT = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10, BR_BEQ = 5'd11, BR_BNE = 5'd12, BR_BLT = 5'd13;
    localparam logic [4:0] ALU_JALR = 5'd17, ALU_MUL = 5'd18;
    localparam logic [1:0] OP1_X = 2'd0, OP1_RS1 = 2'd1, OP1_PC = 2'd2;
    localparam logic [2:0] OP2_X = 3'd0, OP2_RS2 = 3'd1, OP2_IMI = 3'd2, OP2_IMS = 3'd3, OP2_IMJ = 3'd4, OP2_IMU = 3'd5;
    localparam logic MEN_X = 1'b0, MEN_S = 1'b1, REN_X = 1'b0, REN_S = 1'b1;
    localparam logic [1:0] WB_X = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC = 2'd3;

    typedef struct packed {
        logic            valid;
        logic            is_load;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      fn;
        logic [1:0]      op1;
        logic [2:0]      op2;
        logic            mem_wen;
        logic            rf_wen;
        logic [1:0]      wb_sel;
        logic            illegal;
    } slot_t;

    slot_t            slot_q, slot_d, dec;
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;
    logic             ok, hazard, uses_rs1, uses_rs2, fire_in, fire_out;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_j, imm_u;

    function automatic logic [4:0] alu_fn(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign opc   = if_inst[6:0];
    assign f3    = if_inst[14:12];
    assign f7    = if_inst[31:25];
    assign imm_i = XLEN'($signed(if_inst[31:20]));
    assign imm_s = XLEN'($signed({if_inst[31:25], if_inst[11:7]}));
    assign imm_b = XLEN'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({if_inst[31:12], 12'b0}));

    always_comb begin
        dec       = '0;
        ok        = 1'b1;
        dec.valid = 1'b1;
        dec.pc    = if_pc;
        dec.rs1   = if_inst[19:15];
        dec.rs2   = if_inst[24:20];
        dec.rd    = if_inst[11:7];
        case (opc)
            7'h03: begin
                ok = f3 == 3'b010;
                dec.is_load = 1'b1;
                {dec.fn, dec.op1, dec.op2, dec.rf_wen, dec.wb_sel, dec.imm} = {ALU_ADD, OP1_RS1, OP2_IMI, REN_S, WB_MEM, imm_i};
            end
            7'h23: begin
                ok = f3 == 3'b010;
                {dec.fn, dec.op1, dec.op2, dec.mem_wen, dec.wb_sel, dec.imm} = {ALU_ADD, OP1_RS1, OP2_IMS, MEN_S, WB_X, imm_s};
            end
            7'h13: begin
                ok = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
                dec.fn = alu_fn(f3, f3 == 3'b101 && f7[5]);
                {dec.op1, dec.op2, dec.rf_wen, dec.wb_sel, dec.imm} = {OP1_RS1, OP2_IMI, REN_S, WB_ALU, imm_i};
            end
            7'h33: begin
                // funct7=0000001 selects the M-extension group, ordered by funct3
                ok = f7 == 7'b0000001 ? ENABLE_M : (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                dec.fn = f7 == 7'b0000001 ? ALU_MUL + 5'(f3) : alu_fn(f3, f7[5]);
                {dec.op1, dec.op2, dec.rf_wen, dec.wb_sel} = {OP1_RS1, OP2_RS2, REN_S, WB_ALU};
            end
            7'h63: begin
                ok = f3 != 3'b010 && f3 != 3'b011;
                dec.fn = f3 == 3'b000 ? BR_BEQ : f3 == 3'b001 ? BR_BNE : BR_BLT + 5'(f3 - 3'd4);
                {dec.op1, dec.op2, dec.wb_sel, dec.imm} = {OP1_RS1, OP2_RS2, WB_X, imm_b};
            end
            7'h6F: {dec.fn, dec.op1, dec.op2, dec.rf_wen, dec.wb_sel, dec.imm} = {ALU_ADD, OP1_PC, OP2_IMJ, REN_S, WB_PC, imm_j};
            7'h67: begin
                ok = f3 == 3'b000;
                {dec.fn, dec.op1, dec.op2, dec.rf_wen, dec.wb_sel, dec.imm} = {ALU_JALR, OP1_RS1, OP2_IMI, REN_S, WB_PC, imm_i};
            end
            7'h37: {dec.fn, dec.op1, dec.op2, dec.rf_wen, dec.wb_sel, dec.imm} = {ALU_ADD, OP1_X, OP2_IMU, REN_S, WB_ALU, imm_u};
            7'h17: {dec.fn, dec.op1, dec.op2, dec.rf_wen, dec.wb_sel, dec.imm} = {ALU_ADD, OP1_PC, OP2_IMU, REN_S, WB_ALU, imm_u};
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            {dec.is_load, dec.imm, dec.fn, dec.op1, dec.op2} = {1'b0, {XLEN{1'b0}}, ALU_X, OP1_X, OP2_X};
            {dec.mem_wen, dec.rf_wen, dec.wb_sel, dec.illegal} = {MEN_X, REN_X, WB_X, 1'b1};
        end
    end

    // hazard looks at if_inst even without if_valid so if_ready never depends on if_valid
    assign uses_rs1 = !(opc inside {7'h37, 7'h17, 7'h6F});
    assign uses_rs2 = opc inside {7'h33, 7'h63, 7'h23};
    assign hazard   = slot_q.valid && slot_q.is_load && slot_q.rd != 5'd0 &&
                      ((uses_rs1 && if_inst[19:15] == slot_q.rd) || (uses_rs2 && if_inst[24:20] == slot_q.rd));
    assign if_ready = !flush && !hazard && (!slot_q.valid || ex_ready);
    assign fire_in  = if_valid && if_ready;
    assign fire_out = slot_q.valid && ex_ready;

    always_comb begin
        slot_d       = fire_in ? dec : (flush || fire_out) ? '0 : slot_q;
        hazard_cnt_d = (if_valid && hazard && !flush && !(&hazard_cnt_q)) ? hazard_cnt_q + 1'b1 : hazard_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            hazard_cnt_q <= '0;
        end else begin
            slot_q       <= slot_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign id_valid   = slot_q.valid;
    assign id_pc      = slot_q.pc;
    assign id_imm     = slot_q.imm;
    assign op1_addr   = slot_q.rs1;
    assign op2_addr   = slot_q.rs2;
    assign rd_addr    = slot_q.rd;
    assign fn         = slot_q.fn;
    assign op1        = slot_q.op1;
    assign op2        = slot_q.op2;
    assign mem_wen    = slot_q.mem_wen;
    assign rf_wen     = slot_q.rf_wen;
    assign wb_sel     = slot_q.wb_sel;
    assign illegal    = slot_q.illegal;
    assign hazard_cnt = hazard_cnt_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and random checks of two id_stage_pipe configurations against a table-driven model
module tb_id_stage_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_valid, flush, ex_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;

    logic        a_if_ready, a_id_valid, a_mem, a_rf, a_ill;
    logic [31:0] a_id_pc, a_id_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd, a_fn;
    logic [1:0]  a_op1, a_wb;
    logic [2:0]  a_op2;
    logic [15:0] a_cnt;
    logic        b_if_ready, b_id_valid, b_mem, b_rf, b_ill;
    logic [63:0] b_id_pc, b_id_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd, b_fn;
    logic [1:0]  b_op1, b_wb;
    logic [2:0]  b_op2;
    logic [1:0]  b_cnt;

    id_stage_pipe #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(a_if_ready), .if_inst(if_inst), .if_pc(if_pc[31:0]),
        .flush(flush), .id_valid(a_id_valid), .ex_ready(ex_ready), .id_pc(a_id_pc), .id_imm(a_id_imm),
        .op1_addr(a_rs1), .op2_addr(a_rs2), .rd_addr(a_rd), .fn(a_fn), .op1(a_op1), .op2(a_op2),
        .mem_wen(a_mem), .rf_wen(a_rf), .wb_sel(a_wb), .illegal(a_ill), .hazard_cnt(a_cnt));

    id_stage_pipe #(.XLEN(64), .ENABLE_M(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(b_if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .flush(flush), .id_valid(b_id_valid), .ex_ready(ex_ready), .id_pc(b_id_pc), .id_imm(b_id_imm),
        .op1_addr(b_rs1), .op2_addr(b_rs2), .rd_addr(b_rd), .fn(b_fn), .op1(b_op1), .op2(b_op2),
        .mem_wen(b_mem), .rf_wen(b_rf), .wb_sel(b_wb), .illegal(b_ill), .hazard_cnt(b_cnt));

    typedef struct {
        logic [31:0] mask, match;
        logic [4:0]  fn;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic        mem, rf;
        logic [1:0]  wb;
        byte         fmt;
        bit          mext;
    } ent_t;

    typedef struct packed {
        logic [4:0]  fn;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic        mem, rf;
        logic [1:0]  wb;
        logic [63:0] imm;
        logic        illegal, is_lw;
    } exp_t;

    ent_t        tbl[$];
    logic [63:0] sb[$];
    int          n_chk = 0, n_fail = 0;
    bit          m_valid, exp_ready, hz;
    logic [31:0] m_inst;
    logic [63:0] m_pc;
    logic [15:0] m_cnt0;
    logic [1:0]  m_cnt1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] mask, match, input logic [4:0] fn, input logic [1:0] op1,
                       input logic [2:0] op2, input logic mem, rf, input logic [1:0] wb, input byte fmt, input bit mext);
        ent_t t;
        t = '{mask, match, fn, op1, op2, mem, rf, wb, fmt, mext};
        tbl.push_back(t);
    endtask

    task automatic build_table();
        logic [4:0] opf[8] = '{5'd1, 5'd6, 5'd9, 5'd10, 5'd5, 5'd7, 5'd4, 5'd3};
        logic [4:0] brf[8] = '{5'd11, 5'd12, 5'd0, 5'd0, 5'd13, 5'd14, 5'd15, 5'd16};
        add(32'h7F, 32'h37, 5'd1, 2'd0, 3'd5, 1'b0, 1'b1, 2'd1, "U", 1'b0);
        add(32'h7F, 32'h17, 5'd1, 2'd2, 3'd5, 1'b0, 1'b1, 2'd1, "U", 1'b0);
        add(32'h7F, 32'h6F, 5'd1, 2'd2, 3'd4, 1'b0, 1'b1, 2'd3, "J", 1'b0);
        add(32'h707F, 32'h67, 5'd17, 2'd1, 3'd2, 1'b0, 1'b1, 2'd3, "I", 1'b0);
        add(32'h707F, 32'h2003, 5'd1, 2'd1, 3'd2, 1'b0, 1'b1, 2'd2, "I", 1'b0);
        add(32'h707F, 32'h2023, 5'd1, 2'd1, 3'd3, 1'b1, 1'b0, 2'd0, "S", 1'b0);
        add(32'hFE00707F, 32'h40000033, 5'd2, 2'd1, 3'd1, 1'b0, 1'b1, 2'd1, "R", 1'b0);
        add(32'hFE00707F, 32'h40005033, 5'd8, 2'd1, 3'd1, 1'b0, 1'b1, 2'd1, "R", 1'b0);
        add(32'hFE00707F, 32'h40005013, 5'd8, 2'd1, 3'd2, 1'b0, 1'b1, 2'd1, "I", 1'b0);
        for (int f = 0; f < 8; f++) begin
            add(32'hFE00707F, 32'h33 | (32'(f) << 12), opf[f], 2'd1, 3'd1, 1'b0, 1'b1, 2'd1, "R", 1'b0);
            add(32'hFE00707F, 32'h02000033 | (32'(f) << 12), 5'(18 + f), 2'd1, 3'd1, 1'b0, 1'b1, 2'd1, "R", 1'b1);
            add((f == 1 || f == 5) ? 32'hFE00707F : 32'h707F, 32'h13 | (32'(f) << 12), opf[f], 2'd1, 3'd2, 1'b0, 1'b1, 2'd1, "I", 1'b0);
            if (f != 2 && f != 3)
                add(32'h707F, 32'h63 | (32'(f) << 12), brf[f], 2'd1, 3'd1, 1'b0, 1'b0, 2'd0, "B", 1'b0);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] i, input bit men);
        exp_t e;
        e = '0;
        e.illegal = 1'b1;
        foreach (tbl[k])
            if ((i & tbl[k].mask) == tbl[k].match && (!tbl[k].mext || men)) begin
                {e.fn, e.op1, e.op2, e.mem, e.rf, e.wb} = {tbl[k].fn, tbl[k].op1, tbl[k].op2, tbl[k].mem, tbl[k].rf, tbl[k].wb};
                e.illegal = 1'b0;
                e.is_lw = tbl[k].wb == 2'd2;
                case (tbl[k].fmt)
                    "I": e.imm = {{52{i[31]}}, i[31:20]};
                    "S": e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
                    "B": e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                    "U": e.imm = {{32{i[31]}}, i[31:12], 12'h0};
                    "J": e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                    default: e.imm = 64'h0;
                endcase
            end
        return e;
    endfunction

    task automatic cmp_dec(input string p, input exp_t e, input logic [63:0] exp_pc, input logic [63:0] pc, imm,
                           input logic [4:0] rs1, rs2, rd, fn, input logic [1:0] op1, input logic [2:0] op2,
                           input logic mem, rf, input logic [1:0] wb, input logic ill);
        check({p, "_pc"}, pc, exp_pc);
        check({p, "_addrs"}, {rs1, rs2, rd}, {m_inst[19:15], m_inst[24:20], m_inst[11:7]});
        check({p, "_illegal"}, ill, e.illegal);
        check({p, "_fn"}, fn, e.fn);
        check({p, "_wen"}, {mem, rf}, {e.mem, e.rf});
        if (!e.illegal) begin
            check({p, "_sel"}, {op1, op2, wb}, {e.op1, e.op2, e.wb});
            check({p, "_imm"}, imm, e.imm);
        end
    endtask

    task automatic check_slot();
        exp_t e0, e1;
        logic [6:0] opc;
        logic [4:0] rdm;
        bit u1, u2;
        e0 = ref_decode(m_inst, 1'b0);
        e1 = ref_decode(m_inst, 1'b1);
        opc = if_inst[6:0];
        rdm = m_inst[11:7];
        u1 = !(opc inside {7'h37, 7'h17, 7'h6F});
        u2 = opc inside {7'h33, 7'h63, 7'h23};
        hz = m_valid && e0.is_lw && rdm != 5'd0 && ((u1 && if_inst[19:15] == rdm) || (u2 && if_inst[24:20] == rdm));
        exp_ready = !flush && !hz && (!m_valid || ex_ready);
        check("a_if_ready", a_if_ready, exp_ready);
        check("b_if_ready", b_if_ready, exp_ready);
        check("a_id_valid", a_id_valid, m_valid);
        check("b_id_valid", b_id_valid, m_valid);
        check("a_hazard_cnt", a_cnt, m_cnt0);
        check("b_hazard_cnt", b_cnt, m_cnt1);
        if (m_valid) begin
            e0.imm = e0.imm & 64'hFFFF_FFFF;
            cmp_dec("a", e0, m_pc & 64'hFFFF_FFFF, a_id_pc, a_id_imm, a_rs1, a_rs2, a_rd, a_fn, a_op1, a_op2, a_mem, a_rf, a_wb, a_ill);
            cmp_dec("b", e1, m_pc, b_id_pc, b_id_imm, b_rs1, b_rs2, b_rd, b_fn, b_op1, b_op2, b_mem, b_rf, b_wb, b_ill);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc, input logic er, input logic fl);
        bit fin, fout;
        @(negedge clk);
        {if_valid, if_inst, if_pc, ex_ready, flush} = {v, inst, pc, er, fl};
        #1 check_slot();
        fin  = v && exp_ready;
        fout = m_valid && er;
        if (fout && !fl) begin
            if (sb.size() == 0) check("order_underflow", 64'd1, 64'd0);
            else check("order_pc", b_id_pc, sb.pop_front());
        end else if (fl && m_valid && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        @(posedge clk);
        if (v && hz && !fl) begin
            m_cnt0 = m_cnt0 + 16'(m_cnt0 != 16'hFFFF);
            m_cnt1 = m_cnt1 + 2'(m_cnt1 != 2'd3);
        end
        if (fl) m_valid = 1'b0;
        else if (fin) begin
            {m_valid, m_inst, m_pc} = {1'b1, inst, pc};
            sb.push_back(pc);
        end else if (fout) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        {rst, if_valid, flush, ex_ready} = 4'b1000;
        repeat (2) @(posedge clk);
        {m_valid, m_cnt0, m_cnt1} = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_id_valid_a", a_id_valid, 0);
        check("rst_id_valid_b", b_id_valid, 0);
        check("rst_cnt", {a_cnt, b_cnt}, 0);
        check("rst_fields", {a_fn, a_op1, a_op2, a_mem, a_rf, a_wb, a_ill, a_id_imm}, 0);
        check("rst_fields_b", {b_fn, b_op1, b_op2, b_wb, b_ill, b_id_imm}, 0);
    endtask

    function automatic logic [31:0] gen();
        int k;
        logic [31:0] i;
        k = int'($urandom_range(0, 9));
        if (k == 0) return $urandom;
        i = (k < 3) ? 32'h2003 : tbl[$urandom_range(0, tbl.size() - 1)].match;
        if (k >= 3) foreach (tbl[t]) if (tbl[t].match == i) i = ($urandom & ~tbl[t].mask) | i;
        if (k < 3) i = ($urandom & ~32'h707F) | i;
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        i[11:7]  = 5'($urandom_range(0, 3));
        return i;
    endfunction

    initial begin
        {rst, if_valid, flush, ex_ready, if_inst, if_pc} = '0;
        rst = 1'b1;
        {m_inst, m_pc, m_valid, m_cnt0, m_cnt1} = '0;
        build_table();
        do_reset();
        step(1, 32'h00500093, 64'h100, 1, 0);
        #1;
        check("t1_valid", a_id_valid, 1);
        check("t1_rd", a_rd, 1);
        check("t1_imm", a_id_imm, 5);
        check("t1_fn", a_fn, 1);
        check("t1_op2", a_op2, 2);
        check("t1_rf_wb", {a_rf, a_wb, a_ill}, {1'b1, 2'd1, 1'b0});
        step(1, 32'hFFF00093, 64'h104, 1, 0);
        #1;
        check("t2_imm64", b_id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_imm32", a_id_imm, 32'hFFFF_FFFF);
        step(1, 32'h00012283, 64'h108, 1, 0);
        step(1, 32'h00128333, 64'h10C, 1, 0);
        #1;
        check("t3_bubble", a_id_valid, 0);
        check("t3_cnt", a_cnt, 1);
        step(1, 32'h00128333, 64'h10C, 1, 0);
        #1;
        check("t3_issued_rd", {a_id_valid, a_rd}, {1'b1, 5'd6});
        step(1, 32'h00012003, 64'h110, 1, 0);
        step(1, 32'h00100333, 64'h114, 1, 0);
        #1;
        check("t3_x0_nostall", {a_id_valid, a_id_pc}, {1'b1, 32'h114});
        check("t3_x0_cnt", a_cnt, 1);
        step(1, 32'h00500093, 64'h118, 1, 0);
        repeat (3) step(1, 32'h00100333, 64'h11C, 0, 0);
        #1;
        check("t4_held_pc", a_id_pc, 32'h118);
        check("t4_ready", a_if_ready, 0);
        step(1, 32'h00100333, 64'h11C, 0, 1);
        #1;
        check("t4_flush_valid", a_id_valid, 0);
        check("t4_flush_fields", {a_fn, a_rd, a_id_imm, a_rf}, 0);
        step(1, 32'h00100333, 64'h120, 1, 0);
        #1;
        check("t4_resume", {a_id_valid, a_id_pc}, {1'b1, 32'h120});
        step(1, 32'h022081B3, 64'h124, 1, 0);
        #1;
        check("t5_m0_illegal", {a_ill, a_rf}, 2'b10);
        check("t5_m1_mul", {b_ill, b_fn, b_op2, b_rf}, {1'b0, 5'd18, 3'd1, 1'b1});
        step(1, 32'h00012283, 64'h128, 1, 0);
        repeat (5) step(1, 32'h00128333, 64'h12C, 0, 0);
        #1;
        check("sat_cnt_b", b_cnt, 3);
        check("sat_cnt_a", a_cnt, 6);
        step(1, 32'h00128333, 64'h12C, 0, 1);
        #1;
        check("flush_hazard_cnt", a_cnt, 6);
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, gen(), {$urandom, $urandom & 32'hFFFF_FFFC}, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        step(1, 32'h00500093, 64'h200, 1, 0);
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
